bt_cmd_seq: RTL and testbench
=============================

// Module: bt_cmd_seq
// PURPOSE
//  Parametrised RN-52 command sequencer; next generation of the single-flow bluetooth interface FSM.
//  After a power-up delay it issues NUM_INIT init commands, then one command per button-release
//  pulse from NUM_BTN buttons. Waits on a response with timeout and bounded retry.
//  Drives the existing snd_cmd UART block (send/cmd_start/cmd_len, resp_rcvd back).
// PARAMETERS
//  PWRUP_CYCLES   131071  clocks from reset release to first init command and to cmd_n low
//  NUM_INIT       2       init commands sent in table order (1..8)
//  NUM_BTN        2       button inputs, each mapped to one table command (1..8)
//  ADDR_W         5       width of cmd_start (command ROM byte address)
//  LEN_W          4       width of cmd_len (command byte count)
//  TIMEOUT_CYCLES 1000000 clocks to wait for resp_rcvd after send before retrying
//  MAX_RETRY      2       resends per command before fatal error (0 = no retry)
// PORTS
//  clk        in   1           system clock, all logic on posedge
//  rst        in   1           synchronous, active-high reset
//  btn_rel    in   NUM_BTN     1-clk release pulses, already debounced (PB_release per button)
//  resp_rcvd  in   1           1-clk pulse from snd_cmd: response to last command received
//  send       out  1           1-clk pulse: start transmitting cmd_start/cmd_len
//  cmd_start  out  ADDR_W      command start address, valid from send until response/timeout
//  cmd_len    out  LEN_W       command length, same validity as cmd_start
//  cmd_n      out  1           RN-52 CMD pin, active low; 1 until power-up delay expires
//  init_done  out  1           1 once every init command has been acknowledged
//  busy       out  1           1 while a command is outstanding (send issued, no response yet)
//  err        out  1           sticky fatal error: a command exhausted MAX_RETRY
// BEHAVIOUR
//  Reset: send=0, cmd_n=1, init_done=0, busy=0, err=0, cmd_start=0, cmd_len=0. Counters and
//   pending mask cleared. rst is sampled only on clk. A mid-command rst aborts with no further send.
//  States: PWRUP -> ISSUE -> WAIT -> (ISSUE | IDLE | FAULT); IDLE -> ISSUE.
//  PWRUP: count to PWRUP_CYCLES-1, then cmd_n<=0 (held low until rst) and go to ISSUE, idx=0.
//  ISSUE (1 clk): cmd_start/cmd_len loaded from table[idx]; send=1; busy=1; timer cleared; -> WAIT.
//  WAIT: timer increments each clk.
//   - resp_rcvd: busy=0, retry cnt cleared. Init phase with idx<NUM_INIT-1: idx++ and -> ISSUE.
//     Last init: init_done<=1, -> IDLE. Button phase: -> IDLE.
//   - timer==TIMEOUT_CYCLES-1 with no response: if retry<MAX_RETRY, retry++ and -> ISSUE with
//     the same idx. Otherwise err<=1, busy=0, -> FAULT.
//   - resp_rcvd in the same clk as timeout expiry: response wins.
//  IDLE: if pend!=0, idx=NUM_INIT+lowest set bit of pend (lowest index has priority), clear
//   that bit, -> ISSUE. resp_rcvd in IDLE/PWRUP/FAULT is ignored.
//  Pending mask, every clk except reset: pend <= (pend & ~clr) | btn_rel.
//   - Presses are captured in any state, including PWRUP and init.
//   - Repeat presses of a pending button merge into one command.
//   - A press in the same clk its bit is cleared re-sets the bit, so one more command follows.
//  FAULT: terminal until rst; no send; pend keeps updating but is never serviced.
//  Latency: btn_rel pulse in IDLE -> send exactly 2 clks later (pend reg, then ISSUE).
//  Widths: PWRUP counter $clog2(PWRUP_CYCLES); timer $clog2(TIMEOUT_CYCLES);
//   retry $clog2(MAX_RETRY+1), min 1; idx $clog2(NUM_INIT+NUM_BTN), min 1.
//  No wrap: counters saturate at the terminal value because the FSM leaves the state.
//  cmd_start/cmd_len change only in ISSUE.
// STRUCTURE
//  bt_pkg: state_t enum {PWRUP,ISSUE,WAIT,IDLE,FAULT}; the command table as a localparam array
//   of {start,len} pairs (init entries first, then buttons). Defaults: init {0,6},{6,10};
//   btn0 (next) {16,4}; btn1 (prev) {20,10}.
//  Sub-module bt_cmd_rom: combinational idx -> {cmd_start,cmd_len} lookup on the bt_pkg table.
//   Out-of-range idx returns {0,0}.
//  All sequencing, counters and pending logic live in bt_cmd_seq.
// TESTING  (PWRUP_CYCLES=16, TIMEOUT_CYCLES=20, MAX_RETRY=2, defaults otherwise)
//  1. Release rst -> cmd_n=1 for 16 clks, then 0. send pulses with {0,6}. resp 5 clks later ->
//     send with {6,10}. resp -> init_done=1, busy=0.
//  2. After init, btn_rel=2'b01 for 1 clk -> send exactly 2 clks later with {16,4}. resp -> IDLE.
//  3. btn_rel=2'b11 in one clk while idle -> {16,4} first; after resp -> {20,10}. Exactly 2 sends.
//  4. No resp to first init -> send repeated with {0,6} every 21 clks, 3 sends total, then err=1
//     with no further send. A later btn_rel produces no send.
//  5. resp_rcvd in the same clk as timeout expiry -> no resend, proceeds to next command. btn0
//     pressed 3x while busy -> exactly one {16,4}.
//  6. Assert rst in WAIT -> next clk all outputs at reset values and pend=0. Full init then repeats.

Source files
------------

// File: rtl/bt_pkg.sv
// Shared types and command table for the RN-52 command sequencer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package bt_pkg;

  typedef enum logic [2:0] {PWRUP, ISSUE, WAIT, IDLE, FAULT} state_t;

  // One command ROM entry: byte address and byte count inside the snd_cmd ROM
  typedef struct packed {
    logic [7:0] start;
    logic [7:0] len;
  } cmd_ent_t;

  // Init commands first (sent in order), then one entry per button
  localparam int CMD_TBL_N = 4;
  localparam cmd_ent_t CMD_TBL [CMD_TBL_N] = '{
    '{start: 8'd0,  len: 8'd6},   // init 0
    '{start: 8'd6,  len: 8'd10},  // init 1
    '{start: 8'd16, len: 8'd4},   // btn0: next track
    '{start: 8'd20, len: 8'd10}   // btn1: previous track
  };

  // Counter width that still yields at least one bit for degenerate parameters
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/bt_cmd_seq_if.sv
// Handshake bundle between the command sequencer and its environment (buttons, snd_cmd).
// Latency: n/a (wires only).
// Backpressure: none; resp_rcvd is the only return path from snd_cmd.
interface bt_cmd_seq_if #(
  parameter int NUM_BTN = 2,
  parameter int ADDR_W  = 5,
  parameter int LEN_W   = 4
);
  logic [NUM_BTN-1:0] btn_rel;
  logic               resp_rcvd;
  logic               send;
  logic [ADDR_W-1:0]  cmd_start;
  logic [LEN_W-1:0]   cmd_len;
  logic               cmd_n;
  logic               init_done;
  logic               busy;
  logic               err;

  modport master (
    input  btn_rel, resp_rcvd,
    output send, cmd_start, cmd_len, cmd_n, init_done, busy, err
  );

  modport slave (
    output btn_rel, resp_rcvd,
    input  send, cmd_start, cmd_len, cmd_n, init_done, busy, err
  );
endinterface

// File: rtl/bt_cmd_rom.sv
// Combinational command-table lookup: idx -> {cmd_start, cmd_len}; unknown idx gives {0,0}.
// Latency: 0 cycles.
// Backpressure: none.
module bt_cmd_rom
  import bt_pkg::*;
#(
  parameter int IDX_W  = 2,
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 4
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] cmd_start,
  output logic [LEN_W-1:0]  cmd_len
);

  // Table walk so an index past the table end falls through to zero
  always_comb begin
    cmd_start = '0;
    cmd_len   = '0;
    for (int i = 0; i < CMD_TBL_N; i++) begin
      if (int'(idx) == i) begin
        cmd_start = ADDR_W'(CMD_TBL[i].start);
        cmd_len   = LEN_W'(CMD_TBL[i].len);
      end
    end
  end

endmodule

// File: rtl/bt_cmd_seq.sv
// RN-52 command sequencer: power-up delay, init commands, then one command per button release.
// Latency: btn_rel in IDLE -> send 2 clks later; response -> next init send 1 clk later.
// Backpressure: one command outstanding; presses merge in a pending mask until serviced.
module bt_cmd_seq
  import bt_pkg::*;
#(
  parameter int PWRUP_CYCLES   = 131071,
  parameter int NUM_INIT       = 2,
  parameter int NUM_BTN        = 2,
  parameter int ADDR_W         = 5,
  parameter int LEN_W          = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 2
) (
  input logic          clk,
  input logic          rst,
  bt_cmd_seq_if.master bus
);

  localparam int PW_W  = clog2_min1(PWRUP_CYCLES);
  localparam int TM_W  = clog2_min1(TIMEOUT_CYCLES);
  localparam int RT_W  = clog2_min1(MAX_RETRY + 1);
  localparam int IDX_W = clog2_min1(NUM_INIT + NUM_BTN);

  state_t             state;
  logic [PW_W-1:0]    pwr_cnt;
  logic [TM_W-1:0]    timer;
  logic [RT_W-1:0]    retry;
  logic [IDX_W-1:0]   idx;
  logic [NUM_BTN-1:0] pend;

  logic [NUM_BTN-1:0] low_bit;
  logic [NUM_BTN-1:0] clr;
  logic [IDX_W-1:0]   low_idx;
  logic [IDX_W-1:0]   issue_idx;
  logic [ADDR_W-1:0]  rom_start;
  logic [LEN_W-1:0]   rom_len;
  logic               to_issue;
  logic               pwr_exp;
  logic               tmo;
  logic               more_init;
  logic               last_init;
  logic               can_retry;

  bt_cmd_rom #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rom (
    .idx       (issue_idx),
    .cmd_start (rom_start),
    .cmd_len   (rom_len)
  );

  // Decide whether the next clk is an ISSUE and which table entry it sends
  always_comb begin
    low_bit   = pend & (~pend + NUM_BTN'(1));
    low_idx   = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pend[i]) low_idx = IDX_W'(NUM_INIT + i);
    end
    pwr_exp   = (pwr_cnt == PW_W'(PWRUP_CYCLES - 1));
    tmo       = (timer == TM_W'(TIMEOUT_CYCLES - 1));
    more_init = (int'(idx) < NUM_INIT - 1);
    last_init = (int'(idx) == NUM_INIT - 1);
    can_retry = (int'(retry) < MAX_RETRY);
    issue_idx = idx;
    to_issue  = 1'b0;
    clr       = '0;
    case (state)
      PWRUP: begin
        issue_idx = '0;
        to_issue  = pwr_exp;
      end
      WAIT: begin
        if (bus.resp_rcvd) begin
          if (more_init) begin
            issue_idx = idx + IDX_W'(1);
            to_issue  = 1'b1;
          end
        end else if (tmo && can_retry) begin
          to_issue = 1'b1;
        end
      end
      IDLE: begin
        if (|pend) begin
          issue_idx = low_idx;
          to_issue  = 1'b1;
          clr       = low_bit;
        end
      end
      default: ;
    endcase
  end

  // Sequencer state, counters, pending mask and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PWRUP;
      pwr_cnt       <= '0;
      timer         <= '0;
      retry         <= '0;
      idx           <= '0;
      pend          <= '0;
      bus.send      <= 1'b0;
      bus.cmd_start <= '0;
      bus.cmd_len   <= '0;
      bus.cmd_n     <= 1'b1;
      bus.init_done <= 1'b0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      pend     <= (pend & ~clr) | bus.btn_rel;
      bus.send <= to_issue;
      case (state)
        PWRUP: begin
          if (pwr_exp) begin
            bus.cmd_n <= 1'b0;
            state     <= ISSUE;
          end else begin
            pwr_cnt <= pwr_cnt + PW_W'(1);
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + TM_W'(1);
          if (bus.resp_rcvd) begin
            bus.busy <= 1'b0;
            retry    <= '0;
            if (more_init) begin
              state <= ISSUE;
            end else begin
              if (last_init) bus.init_done <= 1'b1;
              state <= IDLE;
            end
          end else if (tmo) begin
            if (can_retry) begin
              retry <= retry + RT_W'(1);
              state <= ISSUE;
            end else begin
              bus.err  <= 1'b1;
              bus.busy <= 1'b0;
              state    <= FAULT;
            end
          end
        end
        IDLE: begin
          if (|pend) state <= ISSUE;
        end
        FAULT: ;
        default: state <= FAULT;
      endcase
      // Entering ISSUE: latch the command so it is stable from send until the reply
      if (to_issue) begin
        idx           <= issue_idx;
        bus.cmd_start <= rom_start;
        bus.cmd_len   <= rom_len;
        bus.busy      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bt_cmd_seq.sv
// Self-checking bench for bt_cmd_seq: directed corner cases, a vector table and random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_bt_cmd_seq;

  localparam int PWRUP     = 16;
  localparam int TMO       = 20;
  localparam int MAX_RETRY = 2;
  localparam int NUM_INIT  = 2;
  localparam int NUM_BTN   = 2;

  logic clk;
  logic rst;

  bt_cmd_seq_if #(.NUM_BTN(NUM_BTN), .ADDR_W(5), .LEN_W(4)) bif ();

  bt_cmd_seq #(
    .PWRUP_CYCLES(PWRUP), .NUM_INIT(NUM_INIT), .NUM_BTN(NUM_BTN), .ADDR_W(5),
    .LEN_W(4), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tb_start [4] = '{0, 6, 16, 20};
  int tb_len   [4] = '{6, 10, 4, 10};

  int checks = 0;
  int errors = 0;
  int nsend  = 0;

  // Reference model: absolute cycle stamps, t = observations since reset release
  int       t;
  int       m_cur;       // command in flight, -1 when none
  int       m_last;      // last command sent, -1 since reset
  int       m_sent_at;   // observation at which m_cur was last sent
  int       m_tries;     // sends so far of m_cur
  bit       m_idle, m_fault, m_done, m_cmdn_low, m_send;
  bit [1:0] m_pend;

  typedef struct {
    logic [1:0] btn;
    int         n;
    int         s0, l0, s1, l1;
  } vec_t;
  vec_t vecs [3];

  int n;
  int base;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0d expected=%0d", nm, t, act, exp);
    end
  endtask

  task automatic m_reset();
    t = 0; m_cur = -1; m_last = -1; m_sent_at = 0; m_tries = 0;
    m_idle = 0; m_fault = 0; m_done = 0; m_cmdn_low = 0; m_send = 0; m_pend = '0;
  endtask

  // Advance the model by one clk given the inputs presented for that edge
  task automatic model_adv(input bit r, input bit rs, input bit [1:0] b);
    int nxt;
    int lo;
    bit [1:0] np;
    if (r) begin
      m_reset();
      return;
    end
    nxt = -1;
    np  = m_pend | b;
    if (!m_cmdn_low) begin
      if (t + 1 == PWRUP) begin
        m_cmdn_low = 1;
        nxt = 0;
      end
    end else if (m_cur >= 0) begin
      if (rs && t > m_sent_at) begin
        if (m_cur < NUM_INIT - 1) nxt = m_cur + 1;
        else begin
          if (m_cur == NUM_INIT - 1) m_done = 1;
          m_idle = 1;
        end
        m_cur = -1;
        m_tries = 0;
      end else if (t + 1 == m_sent_at + TMO + 1) begin
        if (m_tries <= MAX_RETRY) nxt = m_cur;
        else begin
          m_fault = 1;
          m_cur = -1;
        end
      end
    end else if (m_idle && m_pend != 0) begin
      lo = 0;
      for (int i = NUM_BTN - 1; i >= 0; i--) if (m_pend[i]) lo = i;
      np = m_pend;
      np[lo] = 1'b0;
      np = np | b;
      nxt = NUM_INIT + lo;
    end
    if (nxt >= 0) begin
      if (nxt == m_cur) m_tries++;
      else m_tries = 1;
      m_cur = nxt; m_last = nxt; m_sent_at = t + 1; m_idle = 0;
    end
    m_send = (nxt >= 0);
    m_pend = np;
    t++;
  endtask

  task automatic check_outputs();
    if (bif.send === 1'b1) nsend++;
    chk("send",      int'(bif.send),      int'(m_send));
    chk("cmd_start", int'(bif.cmd_start), (m_last < 0) ? 0 : tb_start[m_last]);
    chk("cmd_len",   int'(bif.cmd_len),   (m_last < 0) ? 0 : tb_len[m_last]);
    chk("cmd_n",     int'(bif.cmd_n),     int'(!m_cmdn_low));
    chk("init_done", int'(bif.init_done), int'(m_done));
    chk("busy",      int'(bif.busy),      (m_cur >= 0) ? 1 : 0);
    chk("err",       int'(bif.err),       int'(m_fault));
  endtask

  // One clk: check current outputs, present inputs, step the model, move to next negedge
  task automatic tick(input bit r, input bit rs, input bit [1:0] b);
    check_outputs();
    rst = r;
    bif.resp_rcvd = rs;
    bif.btn_rel = b;
    model_adv(r, rs, b);
    @(negedge clk);
  endtask

  task automatic run(input int k);
    repeat (k) tick(1'b0, 1'b0, 2'b00);
  endtask

  task automatic do_resp(input int k);
    run(k);
    tick(1'b0, 1'b1, 2'b00);
  endtask

  task automatic wait_send(input string nm, input int max, output int cnt);
    cnt = 0;
    while (bif.send !== 1'b1 && cnt < max) begin
      tick(1'b0, 1'b0, 2'b00);
      cnt++;
    end
    if (bif.send !== 1'b1) chk({nm, "_no_send"}, 0, 1);
  endtask

  // Hold reset, check reset values, release and measure the power-up delay
  task automatic power_up(input int rst_clks);
    int c;
    repeat (rst_clks) tick(1'b1, 1'b0, 2'b00);
    chk("rst_send", int'(bif.send), 0);
    chk("rst_cmd_n", int'(bif.cmd_n), 1);
    chk("rst_busy", int'(bif.busy), 0);
    chk("rst_init_done", int'(bif.init_done), 0);
    chk("rst_err", int'(bif.err), 0);
    chk("rst_cmd_start", int'(bif.cmd_start), 0);
    chk("rst_cmd_len", int'(bif.cmd_len), 0);
    c = 0;
    while (bif.cmd_n === 1'b1 && c < 40) begin
      tick(1'b0, 1'b0, 2'b00);
      c++;
    end
    chk("pwrup_cmd_n_high_clks", c, PWRUP);
    chk("pwrup_first_send", int'(bif.send), 1);
    chk("pwrup_first_start", int'(bif.cmd_start), 0);
    chk("pwrup_first_len", int'(bif.cmd_len), 6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0d actual=timeout expected=finish", t);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{btn: 2'b01, n: 1, s0: 16, l0: 4,  s1: 0,  l1: 0};
    vecs[1] = '{btn: 2'b10, n: 1, s0: 20, l0: 10, s1: 0,  l1: 0};
    vecs[2] = '{btn: 2'b11, n: 2, s0: 16, l0: 4,  s1: 20, l1: 10};

    rst = 1'b1;
    bif.resp_rcvd = 1'b0;
    bif.btn_rel = '0;
    repeat (2) @(negedge clk);
    m_reset();

    // Power-up and both init commands acknowledged
    power_up(3);
    do_resp(4);
    chk("init1_send", int'(bif.send), 1);
    chk("init1_start", int'(bif.cmd_start), 6);
    chk("init1_len", int'(bif.cmd_len), 10);
    do_resp(2);
    chk("init_done_set", int'(bif.init_done), 1);
    chk("init_busy_clear", int'(bif.busy), 0);

    // Button vectors from idle: latency, command contents, number of sends
    for (int v = 0; v < 3; v++) begin
      base = nsend;
      tick(1'b0, 1'b0, vecs[v].btn);
      n = 1;
      while (bif.send !== 1'b1 && n < 10) begin
        tick(1'b0, 1'b0, 2'b00);
        n++;
      end
      chk("btn_latency", n, 2);
      chk("btn_first_start", int'(bif.cmd_start), vecs[v].s0);
      chk("btn_first_len", int'(bif.cmd_len), vecs[v].l0);
      do_resp(3);
      if (vecs[v].n == 2) begin
        wait_send("btn_second", 10, n);
        chk("btn_second_start", int'(bif.cmd_start), vecs[v].s1);
        chk("btn_second_len", int'(bif.cmd_len), vecs[v].l1);
        do_resp(3);
      end
      run(30);
      chk("btn_send_count", nsend - base, vecs[v].n);
    end

    // Response on the timeout clk wins; repeated presses while busy merge into one
    tick(1'b0, 1'b0, 2'b01);
    wait_send("t5", 10, n);
    for (int i = 0; i < 20; i++)
      tick(1'b0, 1'b0, (i == 3 || i == 7 || i == 11) ? 2'b01 : 2'b00);
    tick(1'b0, 1'b1, 2'b00);
    chk("tmo_resp_no_resend", int'(bif.send), 0);
    chk("tmo_resp_busy", int'(bif.busy), 0);
    base = nsend;
    wait_send("merged", 10, n);
    chk("merged_start", int'(bif.cmd_start), 16);
    do_resp(3);
    run(30);
    chk("merged_send_count", nsend - base, 1);

    // Reset while waiting on a reply, with a press pending; init repeats, press is gone
    tick(1'b0, 1'b0, 2'b10);
    wait_send("t6", 10, n);
    tick(1'b0, 1'b0, 2'b00);
    tick(1'b0, 1'b0, 2'b01);
    power_up(1);
    run(20);
    tick(1'b0, 1'b1, 2'b00);
    chk("init_tmo_resp_send", int'(bif.send), 1);
    chk("init_tmo_resp_start", int'(bif.cmd_start), 6);
    do_resp(2);
    base = nsend;
    run(30);
    chk("pend_cleared_by_rst", nsend - base, 0);
    chk("reinit_done", int'(bif.init_done), 1);

    // No reply at all: three sends of init 0, then sticky error and no service
    power_up(1);
    base = nsend;
    run(80);
    chk("retry_send_count", nsend - base, 3);
    chk("fault_err", int'(bif.err), 1);
    chk("fault_busy", int'(bif.busy), 0);
    base = nsend;
    tick(1'b0, 1'b0, 2'b01);
    run(20);
    chk("fault_no_service", nsend - base, 0);

    // Random presses and replies against the model
    power_up(1);
    do_resp(3);
    wait_send("rnd_init", 10, n);
    do_resp(3);
    for (int i = 0; i < 3000; i++) begin
      tick(1'b0, ($urandom_range(0, 4) == 0),
           {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)});
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
